and2_result_checker: RTL

AND2_RESULT_CHECKER -- requirements
Module: and2_result_checker

---
 rtl/and2_pkg.sv | 26 ++
 rtl/and2_tag_pipe.sv | 47 ++++
 rtl/and2_result_checker.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/and2_pkg.sv
// Shared types and constants for the AND2 result checker.
// The saturating increment keeps err_count pinned at its maximum instead of wrapping.
package and2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ERR_W       = 8;
  localparam int IDX_W       = 8;
  localparam int MAX_LATENCY = 8;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {ERR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + ERR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/and2_tag_pipe.sv
// LATENCY-deep delay line carrying {valid, expected value, vector index} tokens.
// A flush clears every stage behind the input stage, so the newly injected token survives.
module and2_tag_pipe
  import and2_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       in_exp,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [1:0]       out_exp,
  output logic [IDX_W-1:0] out_idx
);

  logic [LATENCY-1:0] valid_r;
  logic [1:0]         exp_r [LATENCY];
  logic [IDX_W-1:0]   idx_r [LATENCY];

  // Token shift register; only the valid bits need a defined reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        exp_r[i] <= 2'b00;
        idx_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      exp_r[0]   <= in_exp;
      idx_r[0]   <= in_idx;
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= flush ? 1'b0 : valid_r[i-1];
        exp_r[i]   <= exp_r[i-1];
        idx_r[i]   <= idx_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[LATENCY-1];
  assign out_exp   = exp_r[LATENCY-1];
  assign out_idx   = idx_r[LATENCY-1];

endmodule

// File: rtl/and2_result_checker.sv
// Drives tagged expected values for a/b through a delay line and scores the
// AND stage result c when each token emerges; reports first failure and count.
module and2_result_checker
  import and2_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int NUM_VECTORS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic [1:0]       c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [1:0]       first_err_exp,
  output logic [1:0]       first_err_act
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic             launch_s;
  logic             inject_s;
  logic [IDX_W-1:0] inj_idx_s;
  logic [IDX_W-1:0] idx_cnt_r;
  logic             out_valid_s;
  logic [1:0]       out_exp_s;
  logic [IDX_W-1:0] out_idx_s;
  logic             cmp_s;
  logic             mismatch_s;
  logic             last_cmp_r;
  logic             busy_s;
  logic             done_s;

  assign launch_s = start && ((state_r == IDLE) || (state_r == DONE));

  // The start cycle itself carries vector 0; RUN carries the following ones.
  always_comb begin
    inject_s  = 1'b0;
    inj_idx_s = idx_cnt_r;
    if (launch_s) begin
      inject_s  = 1'b1;
      inj_idx_s = '0;
    end else if (state_r == RUN) begin
      inject_s  = 1'b1;
      inj_idx_s = idx_cnt_r;
    end else begin
      inject_s  = 1'b0;
      inj_idx_s = idx_cnt_r;
    end
  end

  and2_tag_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush    (launch_s),
    .in_valid (inject_s),
    .in_exp   (a & b),
    .in_idx   (inj_idx_s),
    .out_valid(out_valid_s),
    .out_exp  (out_exp_s),
    .out_idx  (out_idx_s)
  );

  assign cmp_s      = out_valid_s && ((state_r == RUN) || (state_r == DRAIN));
  assign mismatch_s = cmp_s && (c != out_exp_s);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a single-vector run has nothing left to inject after start.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          next_state_s = (LAST_IDX == '0) ? DRAIN : RUN;
        end else begin
          next_state_s = state_r;
        end
      end
      RUN: begin
        if (idx_cnt_r == LAST_IDX) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = RUN;
        end
      end
      DRAIN: begin
        if (last_cmp_r) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Status decode from the upcoming state so the registered flags line up with it.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (next_state_s)
      RUN, DRAIN: busy_s = 1'b1;
      DONE:       done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Registered status outputs; err_count is already final when DONE is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      busy <= busy_s;
      done <= done_s;
      pass <= done_s && (err_count == '0);
    end
  end

  // Vector counter, completion flag, error count and first-failure capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_cnt_r     <= '0;
      last_cmp_r    <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= 2'b00;
      first_err_act <= 2'b00;
    end else if (launch_s) begin
      idx_cnt_r     <= IDX_W'(1);
      last_cmp_r    <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= 2'b00;
      first_err_act <= 2'b00;
    end else begin
      if (state_r == RUN) begin
        idx_cnt_r <= idx_cnt_r + IDX_W'(1);
      end
      if (cmp_s && (out_idx_s == LAST_IDX)) begin
        last_cmp_r <= 1'b1;
      end
      if (mismatch_s) begin
        err_count <= sat_inc(err_count);
        if (err_count == '0) begin
          first_err_idx <= out_idx_s;
          first_err_exp <= out_exp_s;
          first_err_act <= c;
        end
      end
    end
  end

endmodule
